// File: rtl/rvm_mem_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states, port owners,
// bus widths and the round-robin pick function.
package rvm_mem_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;
    localparam logic [STRB_W-1:0] STRB_ALL = 4'hF;

    typedef enum logic [1:0] {
        RVM_ARB_IDLE = 2'd0,
        RVM_ARB_REQ  = 2'd1,
        RVM_ARB_RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        RVM_OWNER_I = 1'b0,
        RVM_OWNER_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              wen;
        logic [STRB_W-1:0] strb;
        logic [XLEN-1:0]   wdata;
    } bus_req_t;

    // Contended picks go to whichever port did not own the previous transaction.
    function automatic owner_t pick_owner(input logic i_req, input logic d_req,
                                          input owner_t last_owner);
        if (i_req && d_req) begin
            if (last_owner == RVM_OWNER_I) return RVM_OWNER_D;
            else                           return RVM_OWNER_I;
        end else if (d_req) begin
            return RVM_OWNER_D;
        end
        return RVM_OWNER_I;
    endfunction

endpackage

// File: rtl/rvm_arb_timer.sv
// Saturating 8-bit response timer; hit marks the TIMEOUT-th cycle spent waiting
// for a response after the bus accepted the request.
module rvm_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // count holds the waiting cycles already elapsed, so the current cycle is count+1.
    assign hit = ({1'b0, count} + 9'd1) == LIMIT;

endmodule

// File: rtl/rvm_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and
// load/store, one outstanding transaction at a time, with a response timeout.
module rvm_mem_arbiter
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rsp,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [XLEN-1:0]   d_addr,
    input  logic              d_wen,
    input  logic [STRB_W-1:0] d_strb,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_gnt,
    output logic              d_rsp,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_strb,
    input  logic              mem_gnt,
    input  logic              mem_rsp,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_state_t state, state_next;
    owner_t     owner, last_owner;
    bus_req_t   hold;
    bus_req_t   fetch_req, data_req;
    logic       timer_hit;
    logic       accept, done;

    assign fetch_req = '{addr: i_addr, wen: 1'b0, strb: STRB_ALL, wdata: '0};
    assign data_req  = '{addr: d_addr, wen: d_wen, strb: d_strb, wdata: d_wdata};

    assign accept = (state == RVM_ARB_REQ) && mem_gnt;
    assign done   = (state == RVM_ARB_RSP) && (mem_rsp || timer_hit);

    rvm_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state == RVM_ARB_RSP),
        .hit   (timer_hit)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            RVM_ARB_IDLE: if (i_req || d_req) state_next = RVM_ARB_REQ;
            RVM_ARB_REQ:  if (mem_gnt)        state_next = RVM_ARB_RSP;
            RVM_ARB_RSP:  if (done)           state_next = RVM_ARB_IDLE;
            default:                          state_next = RVM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RVM_ARB_IDLE;
            owner      <= RVM_OWNER_D;
            last_owner <= RVM_OWNER_D;
            hold       <= '0;
        end else begin
            state <= state_next;
            if (state == RVM_ARB_IDLE && (i_req || d_req)) begin
                owner <= pick_owner(i_req, d_req, last_owner);
                hold  <= (pick_owner(i_req, d_req, last_owner) == RVM_OWNER_D) ? data_req : fetch_req;
            end
            if (done) last_owner <= owner;
        end
    end

    // Bus fields come straight from the holding registers, never from the ports.
    assign mem_req   = (state == RVM_ARB_REQ);
    assign mem_addr  = hold.addr;
    assign mem_wen   = hold.wen;
    assign mem_strb  = hold.strb;
    assign mem_wdata = hold.wdata;

    // Handshake pulses are Mealy and suppressed while reset aborts a transaction;
    // the response beats the timeout when both land on the same cycle.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        i_rsp   = 1'b0;
        d_rsp   = 1'b0;
        i_err   = 1'b0;
        d_err   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (!reset) begin
            if (owner == RVM_OWNER_I) begin
                i_gnt   = accept;
                i_rsp   = done;
                i_err   = done && !mem_rsp;
                i_rdata = (done && mem_rsp) ? mem_rdata : '0;
            end else begin
                d_gnt   = accept;
                d_rsp   = done;
                d_err   = done && !mem_rsp;
                d_rdata = (done && mem_rsp) ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed bench for rvm_mem_arbiter: stimulus pushes expected grants/responses
// into queues and a negedge monitor pops and compares them as the DUT emits them.
module tb_rvm_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wen, mem_gnt, mem_rsp;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_strb;
    logic        i_gnt, i_rsp, i_err, d_gnt, d_rsp, d_err, mem_req, mem_wen;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_strb;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];
    int checks = 0;
    int errors = 0;

    rvm_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rsp(i_rsp),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_strb(d_strb),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rsp(d_rsp), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_gnt(mem_gnt),
        .mem_rsp(mem_rsp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic port, input logic [31:0] addr, input logic wen,
                            input logic [3:0] strb, input logic [31:0] wdata);
        gnt_exp_t g;
        g.port = port; g.addr = addr; g.wen = wen; g.strb = strb; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic push_rsp(input logic port, input logic [31:0] rdata, input logic err);
        rsp_exp_t r;
        r.port = port; r.rdata = rdata; r.err = err;
        rq.push_back(r);
    endtask

    // Monitor: any grant or response pops the next expectation; idle ports must stay quiet.
    always @(negedge clk) begin
        gnt_exp_t g;
        rsp_exp_t r;
        check("quiet", 32'({i_gnt && d_gnt, i_rsp && d_rsp,
                            !i_rsp && i_rdata != 0, !d_rsp && d_rdata != 0,
                            i_err && !i_rsp, d_err && !d_rsp}), 32'd0);
        if (i_gnt || d_gnt) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL gnt_unexpected: got i_gnt=%b d_gnt=%b expected none", i_gnt, d_gnt);
            end else begin
                g = gq.pop_front();
                check("gnt_port", 32'(d_gnt), 32'(g.port));
                check("gnt_mem_req", 32'(mem_req), 32'd1);
                check("gnt_addr", mem_addr, g.addr);
                check("gnt_wen", 32'(mem_wen), 32'(g.wen));
                check("gnt_strb", 32'(mem_strb), 32'(g.strb));
                check("gnt_wdata", mem_wdata, g.wdata);
            end
        end
        if (i_rsp || d_rsp) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got i_rsp=%b d_rsp=%b expected none", i_rsp, d_rsp);
            end else begin
                r = rq.pop_front();
                check("rsp_port", 32'(d_rsp), 32'(r.port));
                check("rsp_rdata", r.port ? d_rdata : i_rdata, r.rdata);
                check("rsp_err", 32'(r.port ? d_err : i_err), 32'(r.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        // Contention stimulus is already present while reset is held.
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300; d_wen = 1'b0; d_strb = 4'hF; d_wdata = '0;
        mem_gnt = 1'b1; mem_rsp = 1'b1; mem_rdata = 32'hC0DE0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_gnt", 32'({i_gnt, d_gnt, i_rsp, d_rsp}), 32'd0);

        // Contention: I, D, I, D with a 3-cycle period.
        for (int k = 0; k < 4; k++) begin
            push_gnt(k[0], k[0] ? 32'h300 : 32'h200, 1'b0, 4'hF, 32'd0);
            push_rsp(k[0], 32'hC0DE0001, 1'b0);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("cont_mem_req", 32'(mem_req), 32'((c % 3) == 1));
            step();
        end
        i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rsp = 1'b0;
        step();

        // Single fetch.
        i_req = 1'b1; i_addr = 32'h100; mem_gnt = 1'b1;
        push_gnt(1'b0, 32'h100, 1'b0, 4'hF, 32'd0);
        push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("fetch_n_mem_req", 32'(mem_req), 32'd0);
        step();
        @(negedge clk);
        check("fetch_gnt_n1", 32'(i_gnt), 32'd1);
        step();
        i_req = 1'b0; mem_gnt = 1'b0; mem_rsp = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("fetch_rsp_n2", 32'(i_rsp), 32'd1);
        check("fetch_rdata", i_rdata, 32'hDEADBEEF);
        step();
        mem_rsp = 1'b0;

        // Store with the bus stalling three cycles.
        d_req = 1'b1; d_addr = 32'h400; d_wen = 1'b1; d_strb = 4'b0011; d_wdata = 32'h1234ABCD;
        push_gnt(1'b1, 32'h400, 1'b1, 4'b0011, 32'h1234ABCD);
        push_rsp(1'b1, 32'h5555AAAA, 1'b0);
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) mem_gnt = 1'b1;
            @(negedge clk);
            check("store_mem_req", 32'(mem_req), 32'd1);
            check("store_addr", mem_addr, 32'h400);
            check("store_ctl", 32'({mem_wen, mem_strb}), 32'h13);
            check("store_wdata", mem_wdata, 32'h1234ABCD);
            check("store_d_gnt", 32'(d_gnt), 32'(k == 4));
            step();
        end
        d_req = 1'b0; d_wen = 1'b0; d_strb = 4'hF; d_wdata = '0;
        mem_gnt = 1'b0; mem_rsp = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        check("store_rsp", 32'(d_rsp), 32'd1);
        step();
        mem_rsp = 1'b0;

        // Timeout on a load: error response 4 cycles after accept, then a stray response.
        d_req = 1'b1; d_addr = 32'h500; mem_gnt = 1'b1; mem_rdata = 32'hFFFFFFFF;
        push_gnt(1'b1, 32'h500, 1'b0, 4'hF, 32'd0);
        push_rsp(1'b1, 32'd0, 1'b1);
        step();
        @(negedge clk);
        check("to_accept", 32'(d_gnt), 32'd1);
        step();
        d_req = 1'b0; mem_gnt = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("to_early", 32'(d_rsp), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_rsp", 32'({d_rsp, d_err}), 32'h3);
        check("to_rdata", d_rdata, 32'd0);
        step();
        mem_rsp = 1'b1;
        @(negedge clk);
        check("stray_ignored", 32'({i_rsp, d_rsp, mem_req}), 32'd0);
        step();
        mem_rsp = 1'b0;

        // Response lands on the exact timeout cycle: data wins, no error.
        i_req = 1'b1; i_addr = 32'h600; mem_gnt = 1'b1;
        push_gnt(1'b0, 32'h600, 1'b0, 4'hF, 32'd0);
        push_rsp(1'b0, 32'h600D600D, 1'b0);
        step();
        step();
        i_req = 1'b0; mem_gnt = 1'b0;
        repeat (3) step();
        mem_rsp = 1'b1; mem_rdata = 32'h600D600D;
        @(negedge clk);
        check("race_rsp", 32'({i_rsp, i_err}), 32'h2);
        check("race_rdata", i_rdata, 32'h600D600D);
        step();
        mem_rsp = 1'b0;

        // Reset while waiting for a response aborts the transaction.
        d_req = 1'b1; d_addr = 32'h700; mem_gnt = 1'b1;
        push_gnt(1'b1, 32'h700, 1'b0, 4'hF, 32'd0);
        step();
        step();
        d_req = 1'b0; mem_gnt = 1'b0; mem_rsp = 1'b1; mem_rdata = 32'hBAD0BAD0; reset = 1'b1;
        @(negedge clk);
        check("rst_no_rsp", 32'({i_rsp, d_rsp}), 32'd0);
        step();
        reset = 1'b0; mem_rsp = 1'b0;
        @(negedge clk);
        check("rst_after_req", 32'({mem_req, mem_wen, mem_strb}), 32'd0);
        check("rst_after_addr", mem_addr, 32'd0);
        check("rst_after_wdata", mem_wdata, 32'd0);
        check("rst_after_hs", 32'({i_gnt, d_gnt, i_rsp, d_rsp, i_err, d_err}), 32'd0);
        step();

        // last_owner restored to D: fetch wins the contended pick, then data follows.
        i_req = 1'b1; i_addr = 32'h800;
        d_req = 1'b1; d_addr = 32'h900; mem_gnt = 1'b1;
        push_gnt(1'b0, 32'h800, 1'b0, 4'hF, 32'd0);
        push_rsp(1'b0, 32'h11112222, 1'b0);
        push_gnt(1'b1, 32'h900, 1'b0, 4'hF, 32'd0);
        push_rsp(1'b1, 32'h11112222, 1'b0);
        step();
        @(negedge clk);
        check("rst_last_owner", 32'({i_gnt, d_gnt}), 32'h2);
        step();
        i_req = 1'b0; mem_rsp = 1'b1; mem_rdata = 32'h11112222;
        repeat (3) step();
        d_req = 1'b0; mem_gnt = 1'b0;
        step();
        mem_rsp = 1'b0;
        repeat (3) step();

        check("gq_empty", 32'(gq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
